// File: rtl/cosine_rom_reader_pkg.sv
// Shared types for the cosine ROM read sequencer.
package cosine_rom_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/sample_skid_buf.sv
// Two-entry FIFO that holds ROM words until downstream accepts them.
module sample_skid_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (cnt != 2'd0);
        do_push = push && ((cnt != 2'd2) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign occ        = cnt;
    assign head_data  = mem[rd_ptr];
    assign head_valid = (cnt != 2'd0);

endmodule

// File: rtl/cosine_rom_reader.sv
// Phase-accumulator read sequencer for the cosine ROM; hides the ROM's one-cycle
// read latency and delivers samples on a valid/ready stream.
module cosine_rom_reader
    import cosine_rom_reader_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int DEPTH   = 64,
    parameter int PHASE_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [PHASE_W-1:0]       tuning_word,
    output logic                     rom_en,
    output logic [$clog2(DEPTH)-1:0] rom_addr,
    input  logic [WIDTH-1:0]         rom_data,
    output logic [WIDTH-1:0]         sample_data,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     busy,
    output logic [31:0]              sample_count
);

    localparam int AW = $clog2(DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] tw;
    logic               inflight;
    logic [31:0]        count;
    logic [1:0]         occ;
    logic               pop;
    logic [2:0]         budget;

    // Words committed to the buffer (held or in flight) after this cycle's pop.
    always_comb begin
        pop    = sample_valid & sample_ready;
        budget = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        rom_en = (state == ST_RUN) && (budget < 3'd2);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (stop) state_nxt = ST_DRAIN;
            ST_DRAIN: if ((occ == 2'd0) && !inflight) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase    <= '0;
            tw       <= '0;
            inflight <= 1'b0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= rom_en;
            if ((state == ST_IDLE) && start) begin
                phase <= '0;
                tw    <= tuning_word;
                count <= '0;
            end else begin
                if (rom_en) phase <= phase + tw;
                if (pop) count <= count + 32'd1;
            end
        end
    end

    sample_skid_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (rom_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (sample_data),
        .head_valid(sample_valid)
    );

    assign rom_addr     = phase[PHASE_W-1 -: AW];
    assign busy         = (state != ST_IDLE);
    assign sample_count = count;

endmodule

// File: tb/tb_cosine_rom_reader.sv
// Directed bench for cosine_rom_reader with a stream-level reference model.
module tb_cosine_rom_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] tuning_word = '0;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [63:0] rom_data;
    logic [63:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        busy;
    logic [31:0] sample_count;

    logic [63:0] mem [64];

    int unsigned vectors = 0;
    int unsigned errors = 0;
    int unsigned issued = 0;
    int unsigned accepted = 0;
    logic [15:0] model_tw = '0;

    always #5 clk = ~clk;

    cosine_rom_reader #(
        .WIDTH  (64),
        .DEPTH  (64),
        .PHASE_W(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .tuning_word (tuning_word),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .busy        (busy),
        .sample_count(sample_count)
    );

    // Block-style cosine ROM: registered read, one cycle of latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Table index of the i-th read since start: top 6 bits of i*tw mod 2^16.
    function automatic logic [5:0] exp_addr(input int unsigned i);
        logic [15:0] ph;
        ph = 16'(i * model_tw);
        return ph[15:10];
    endfunction

    always @(negedge clk) begin
        logic p;
        if (!rst) begin
            p = sample_valid & sample_ready;
            check("held_max", 64'((issued - accepted) <= 2), 64'd1);
            check("count", 64'(sample_count), 64'(accepted));
            if (rom_en) begin
                check("issue_addr", 64'(rom_addr), 64'(exp_addr(issued)));
                check("issue_budget", 64'((issued - accepted - int'(p)) < 2), 64'd1);
                issued++;
            end
            if (p) begin
                check("sample", sample_data, mem[exp_addr(accepted)]);
                accepted++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] tw);
        tuning_word = tw;
        model_tw    = tw;
        start       = 1'b1;
        tick();
        issued      = 0;
        accepted    = 0;
        start       = 1'b0;
        tuning_word = 16'hBEEF;
        check("first_en", 64'(rom_en), 64'd1);
        check("first_addr", 64'(rom_addr), 64'd0);
        check("busy_run", 64'(busy), 64'd1);
    endtask

    task automatic wait_accepted(input int unsigned n);
        int unsigned c;
        c = 0;
        while (accepted < n && c < 500) begin
            tick();
            c++;
        end
        check("wait_accepted_timeout", 64'(accepted >= n), 64'd1);
    endtask

    task automatic wait_idle();
        int unsigned c;
        c = 0;
        while (busy && c < 50) begin
            tick();
            c++;
        end
        check("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic stop_and_drain();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle();
    endtask

    initial begin
        int unsigned cyc;
        int unsigned base;
        for (int i = 0; i < 64; i++) begin
            mem[i] = {8'hC5, 24'(i), 32'hA5A5_0000 ^ 32'(i * 37)};
        end

        // Reset values
        tick();
        tick();
        check("rst_en", 64'(rom_en), 64'd0);
        check("rst_addr", 64'(rom_addr), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_data", sample_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(sample_count), 64'd0);
        rst = 1'b0;
        tick();

        // Base sweep, tw=0x0400, ready always high
        sample_ready = 1'b1;
        start_run(16'h0400);
        tick();
        check("lat_valid_low", 64'(sample_valid), 64'd0);
        tick();
        check("lat_valid_high", 64'(sample_valid), 64'd1);
        check("lat_data", sample_data, mem[0]);
        cyc = 0;
        while (accepted < 64 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("throughput_cycles", 64'(cyc), 64'd64);
        check("wrap_data", sample_data, mem[0]);
        wait_accepted(65);
        stop_and_drain();

        // tw=0: every sample is mem[0]
        start_run(16'h0000);
        wait_accepted(8);
        check("tw0_data", sample_data, mem[0]);
        stop_and_drain();

        // tw=0xFC00: addresses run backwards
        start_run(16'hFC00);
        tick();
        tick();
        check("neg_s0", sample_data, mem[0]);
        tick();
        check("neg_s1", sample_data, mem[63]);
        tick();
        check("neg_s2", sample_data, mem[62]);
        stop_and_drain();

        // Backpressure: ready low for 5 cycles mid-stream
        start_run(16'h0400);
        wait_accepted(10);
        sample_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("bp_en_low", 64'(rom_en), 64'd0);
        check("bp_valid", 64'(sample_valid), 64'd1);
        check("bp_head", sample_data, mem[accepted % 64]);
        sample_ready = 1'b1;
        wait_accepted(22);
        check("bp_count", 64'(sample_count), 64'(accepted));
        stop_and_drain();

        // Stop under stall with occ=1 and one read in flight
        start_run(16'h0400);
        wait_accepted(6);
        sample_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("drain_busy", 64'(busy), 64'd1);
        check("drain_en", 64'(rom_en), 64'd0);
        check("drain_valid", 64'(sample_valid), 64'd1);
        base = accepted;
        sample_ready = 1'b1;
        wait_idle();
        check("drain_extra", 64'(accepted - base), 64'd2);
        tick();
        check("idle_en", 64'(rom_en), 64'd0);
        check("idle_valid", 64'(sample_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Reset mid-run with two samples buffered
        start_run(16'h0400);
        wait_accepted(4);
        sample_ready = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_valid", 64'(sample_valid), 64'd1);
        check("pre_rst_en", 64'(rom_en), 64'd0);
        rst = 1'b1;
        tick();
        issued   = 0;
        accepted = 0;
        check("mrst_en", 64'(rom_en), 64'd0);
        check("mrst_addr", 64'(rom_addr), 64'd0);
        check("mrst_valid", 64'(sample_valid), 64'd0);
        check("mrst_data", sample_data, 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_count", 64'(sample_count), 64'd0);
        rst = 1'b0;
        start_run(16'h0400);
        check("restart_count", 64'(sample_count), 64'd0);
        sample_ready = 1'b1;
        wait_accepted(5);
        stop_and_drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
